// File: rtl/vc_mem_arb_4port.sv
// vc_mem_arb_4port
//
// Lets four requesters share one single-port memory.
// - Requests pass through combinationally. A round-robin pointer picks one of the
//   requesters whose valid is high.
// - Each accepted request records the 2-bit id of the granted port in a tag FIFO.
//   The memory returns responses in request order, so the FIFO head says which
//   requester the current response belongs to.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   memreqN_val/rdy/msg  (N=0..3)   requester-side request channels
//   memrespN_val/rdy/msg (N=0..3)   requester-side response channels
//   memreq_val/rdy/msg              request channel to the memory
//   memresp_val/rdy/msg             response channel from the memory

`ifndef VC_MEM_REQ_MSG_SZ
`define VC_MEM_REQ_MSG_SZ(a_, d_) (1 + (a_) + $clog2((d_) / 8) + (d_))
`endif

`ifndef VC_MEM_RESP_MSG_SZ
`define VC_MEM_RESP_MSG_SZ(d_) (1 + $clog2((d_) / 8) + (d_))
`endif

module vc_mem_arb_4port #(
  parameter int p_addr_sz          = 8,
  parameter int p_data_sz          = 32,
  parameter int p_max_outstanding  = 4,
  localparam int c_req_msg_sz      = `VC_MEM_REQ_MSG_SZ(p_addr_sz, p_data_sz),
  localparam int c_resp_msg_sz     = `VC_MEM_RESP_MSG_SZ(p_data_sz)
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     memreq0_val,
  output logic                     memreq0_rdy,
  input  logic [c_req_msg_sz-1:0]  memreq0_msg,
  input  logic                     memreq1_val,
  output logic                     memreq1_rdy,
  input  logic [c_req_msg_sz-1:0]  memreq1_msg,
  input  logic                     memreq2_val,
  output logic                     memreq2_rdy,
  input  logic [c_req_msg_sz-1:0]  memreq2_msg,
  input  logic                     memreq3_val,
  output logic                     memreq3_rdy,
  input  logic [c_req_msg_sz-1:0]  memreq3_msg,

  output logic                     memresp0_val,
  input  logic                     memresp0_rdy,
  output logic [c_resp_msg_sz-1:0] memresp0_msg,
  output logic                     memresp1_val,
  input  logic                     memresp1_rdy,
  output logic [c_resp_msg_sz-1:0] memresp1_msg,
  output logic                     memresp2_val,
  input  logic                     memresp2_rdy,
  output logic [c_resp_msg_sz-1:0] memresp2_msg,
  output logic                     memresp3_val,
  input  logic                     memresp3_rdy,
  output logic [c_resp_msg_sz-1:0] memresp3_msg,

  output logic                     memreq_val,
  input  logic                     memreq_rdy,
  output logic [c_req_msg_sz-1:0]  memreq_msg,

  input  logic                     memresp_val,
  output logic                     memresp_rdy,
  input  logic [c_resp_msg_sz-1:0] memresp_msg
);

  localparam int c_ptr_sz = $clog2(p_max_outstanding);
  localparam int c_cnt_sz = c_ptr_sz + 1;
  localparam logic [c_cnt_sz-1:0] c_full_cnt = c_cnt_sz'(p_max_outstanding);
  localparam logic [c_cnt_sz-1:0] c_one_cnt  = c_cnt_sz'(1);
  localparam logic [c_ptr_sz-1:0] c_one_ptr  = c_ptr_sz'(1);

  // Per-port inputs and outputs gathered into vectors so the port id can index them.
  logic [3:0]              req_val_s;
  logic [c_req_msg_sz-1:0] req_msg_s [4];
  logic [3:0]              resp_rdy_s;
  logic [3:0]              req_rdy_s;
  logic [3:0]              resp_val_s;

  // Arbitration and tag-FIFO state.
  logic [1:0]              ptr_r;
  logic [1:0]              tags_r [p_max_outstanding];
  logic [c_ptr_sz-1:0]     wr_ptr_r;
  logic [c_ptr_sz-1:0]     rd_ptr_r;
  logic [c_cnt_sz-1:0]     count_r;

  logic [1:0]              grant_s;
  logic                    grant_val_s;
  logic [1:0]              cand_s;
  logic                    full_s;
  logic                    empty_s;
  logic [1:0]              head_s;
  logic                    memreq_val_s;
  logic [c_req_msg_sz-1:0] memreq_msg_s;
  logic                    memresp_rdy_s;
  logic                    req_fire_s;
  logic                    resp_fire_s;

  assign req_val_s   = {memreq3_val, memreq2_val, memreq1_val, memreq0_val};
  assign req_msg_s[0] = memreq0_msg;
  assign req_msg_s[1] = memreq1_msg;
  assign req_msg_s[2] = memreq2_msg;
  assign req_msg_s[3] = memreq3_msg;
  assign resp_rdy_s  = {memresp3_rdy, memresp2_rdy, memresp1_rdy, memresp0_rdy};

  assign full_s  = (count_r == c_full_cnt);
  assign empty_s = (count_r == {c_cnt_sz{1'b0}});
  assign head_s  = tags_r[rd_ptr_r];

  // Round-robin search. The loop scans from the farthest offset down to ptr itself,
  // so the nearest valid port is the one that remains in grant_s.
  always_comb begin
    grant_s     = 2'd0;
    grant_val_s = 1'b0;
    cand_s      = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand_s      = ptr_r + 2'(i);
      grant_s     = req_val_s[cand_s] ? cand_s : grant_s;
      grant_val_s = grant_val_s | req_val_s[cand_s];
    end
  end

  // Request side. A full FIFO blocks new requests even when a response pops in the
  // same cycle, which keeps the ready path free of the response handshake.
  always_comb begin
    memreq_val_s = 1'b0;
    memreq_msg_s = {c_req_msg_sz{1'b0}};
    req_rdy_s    = 4'b0000;
    if (grant_val_s && !reset) begin
      memreq_val_s = !full_s;
      memreq_msg_s = req_msg_s[grant_s];
      if (memreq_rdy && !full_s) begin
        req_rdy_s[grant_s] = 1'b1;
      end else begin
        req_rdy_s = 4'b0000;
      end
    end else begin
      memreq_val_s = 1'b0;
      memreq_msg_s = {c_req_msg_sz{1'b0}};
      req_rdy_s    = 4'b0000;
    end
  end

  // Response side. The FIFO head selects the destination. When the FIFO is empty,
  // ready stays low, so an unexpected response is stalled instead of dropped.
  always_comb begin
    resp_val_s    = 4'b0000;
    memresp_rdy_s = 1'b0;
    if (!empty_s && !reset) begin
      resp_val_s[head_s] = memresp_val;
      memresp_rdy_s      = resp_rdy_s[head_s];
    end else begin
      resp_val_s    = 4'b0000;
      memresp_rdy_s = 1'b0;
    end
  end

  assign req_fire_s  = memreq_val_s & memreq_rdy;
  assign resp_fire_s = memresp_val & memresp_rdy_s;

  assign memreq_val   = memreq_val_s;
  assign memreq_msg   = memreq_msg_s;
  assign memresp_rdy  = memresp_rdy_s;
  assign memreq0_rdy  = req_rdy_s[0];
  assign memreq1_rdy  = req_rdy_s[1];
  assign memreq2_rdy  = req_rdy_s[2];
  assign memreq3_rdy  = req_rdy_s[3];
  assign memresp0_val = resp_val_s[0];
  assign memresp1_val = resp_val_s[1];
  assign memresp2_val = resp_val_s[2];
  assign memresp3_val = resp_val_s[3];
  assign memresp0_msg = memresp_msg;
  assign memresp1_msg = memresp_msg;
  assign memresp2_msg = memresp_msg;
  assign memresp3_msg = memresp_msg;

  // Priority pointer: after a fire, the port just served drops to lowest priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= 2'd0;
    end else if (req_fire_s) begin
      ptr_r <= grant_s + 2'd1;
    end
  end

  // Tag storage. Entries carry no reset because count_r marks which ones are live.
  always_ff @(posedge clk) begin
    if (req_fire_s) begin
      tags_r[wr_ptr_r] <= grant_s;
    end
  end

  // FIFO pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {c_ptr_sz{1'b0}};
      rd_ptr_r <= {c_ptr_sz{1'b0}};
    end else begin
      if (req_fire_s) begin
        wr_ptr_r <= wr_ptr_r + c_one_ptr;
      end
      if (resp_fire_s) begin
        rd_ptr_r <= rd_ptr_r + c_one_ptr;
      end
    end
  end

  // Occupancy. A push cannot occur when full and a pop cannot occur when empty,
  // so the count stays in range.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {c_cnt_sz{1'b0}};
    end else begin
      case ({req_fire_s, resp_fire_s})
        2'b10:   count_r <= count_r + c_one_cnt;
        2'b01:   count_r <= count_r - c_one_cnt;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_vc_mem_arb_4port.sv
module tb_vc_mem_arb_4port;

  localparam int REQ_SZ  = 1 + 8 + 2 + 32;
  localparam int RESP_SZ = 1 + 2 + 32;

  logic               clk = 1'b0;
  logic               reset;
  logic [3:0]         rq_val;
  logic [REQ_SZ-1:0]  rq_msg [4];
  wire  [3:0]         rq_rdy;
  wire  [3:0]         rs_val;
  logic [3:0]         rs_rdy;
  wire  [RESP_SZ-1:0] rs_msg [4];
  wire                memreq_val;
  logic               memreq_rdy;
  wire  [REQ_SZ-1:0]  memreq_msg;
  logic               memresp_val;
  wire                memresp_rdy;
  logic [RESP_SZ-1:0] memresp_msg;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vc_mem_arb_4port dut (
    .clk(clk), .reset(reset),
    .memreq0_val(rq_val[0]), .memreq0_rdy(rq_rdy[0]), .memreq0_msg(rq_msg[0]),
    .memreq1_val(rq_val[1]), .memreq1_rdy(rq_rdy[1]), .memreq1_msg(rq_msg[1]),
    .memreq2_val(rq_val[2]), .memreq2_rdy(rq_rdy[2]), .memreq2_msg(rq_msg[2]),
    .memreq3_val(rq_val[3]), .memreq3_rdy(rq_rdy[3]), .memreq3_msg(rq_msg[3]),
    .memresp0_val(rs_val[0]), .memresp0_rdy(rs_rdy[0]), .memresp0_msg(rs_msg[0]),
    .memresp1_val(rs_val[1]), .memresp1_rdy(rs_rdy[1]), .memresp1_msg(rs_msg[1]),
    .memresp2_val(rs_val[2]), .memresp2_rdy(rs_rdy[2]), .memresp2_msg(rs_msg[2]),
    .memresp3_val(rs_val[3]), .memresp3_rdy(rs_rdy[3]), .memresp3_msg(rs_msg[3]),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg)
  );

  task automatic idle();
    rq_val      = 4'b0000;
    for (int n = 0; n < 4; n++) rq_msg[n] = {REQ_SZ{1'b0}};
    rs_rdy      = 4'b0000;
    memreq_rdy  = 1'b0;
    memresp_val = 1'b0;
    memresp_msg = {RESP_SZ{1'b0}};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    rq_val      = 4'b1111;
    for (int n = 0; n < 4; n++) rq_msg[n] = REQ_SZ'(43'h7ff);
    memreq_rdy  = 1'b1;
    memresp_val = 1'b1;
    memresp_msg = RESP_SZ'(35'h123);
    rs_rdy      = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (memreq_val !== 1'b0) begin failures++; $display("FAIL reset_memreq_val: got %b want 0", memreq_val); end
    checks++; if (memreq_msg !== {REQ_SZ{1'b0}}) begin failures++; $display("FAIL reset_memreq_msg: got %h want 0", memreq_msg); end
    checks++; if (rq_rdy !== 4'b0000) begin failures++; $display("FAIL reset_req_rdy: got %b want 0000", rq_rdy); end
    checks++; if (memresp_rdy !== 1'b0) begin failures++; $display("FAIL reset_memresp_rdy: got %b want 0", memresp_rdy); end
    checks++; if (rs_val !== 4'b0000) begin failures++; $display("FAIL reset_resp_val: got %b want 0000", rs_val); end
    checks++; if (dut.count_r !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", dut.count_r); end
    checks++; if (dut.ptr_r !== 2'd0) begin failures++; $display("FAIL reset_ptr: got %0d want 0", dut.ptr_r); end
    idle();
    reset = 1'b0;
  endtask

  task automatic test_single_requester();
    logic [REQ_SZ-1:0]  exp_req;
    logic [RESP_SZ-1:0] exp_resp;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp_req    = REQ_SZ'(43'h200 + 43'(k));
      rq_val     = 4'b0100;
      rq_msg[2]  = exp_req;
      memreq_rdy = 1'b1;
      #1;
      checks++; if (memreq_val !== 1'b1) begin failures++; $display("FAIL single_req_val[%0d]: got %b want 1", k, memreq_val); end
      checks++; if (memreq_msg !== exp_req) begin failures++; $display("FAIL single_req_msg[%0d]: got %h want %h", k, memreq_msg, exp_req); end
      checks++; if (rq_rdy !== 4'b0100) begin failures++; $display("FAIL single_req_rdy[%0d]: got %b want 0100", k, rq_rdy); end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rq_val      = 4'b0000;
      memreq_rdy  = 1'b0;
      exp_resp    = RESP_SZ'(35'h500 + 35'(k));
      memresp_val = 1'b1;
      memresp_msg = exp_resp;
      rs_rdy      = 4'b1111;
      #1;
      checks++; if (rs_val !== 4'b0100) begin failures++; $display("FAIL single_resp_val[%0d]: got %b want 0100", k, rs_val); end
      checks++; if (rs_msg[2] !== exp_resp) begin failures++; $display("FAIL single_resp_msg2[%0d]: got %h want %h", k, rs_msg[2], exp_resp); end
      checks++; if (rs_msg[0] !== exp_resp) begin failures++; $display("FAIL single_resp_msg0[%0d]: got %h want %h", k, rs_msg[0], exp_resp); end
      checks++; if (memresp_rdy !== 1'b1) begin failures++; $display("FAIL single_memresp_rdy[%0d]: got %b want 1", k, memresp_rdy); end
    end
    @(negedge clk);
    #1;
    checks++; if (memresp_rdy !== 1'b0) begin failures++; $display("FAIL empty_stall_rdy: got %b want 0", memresp_rdy); end
    checks++; if (rs_val !== 4'b0000) begin failures++; $display("FAIL empty_stall_val: got %b want 0000", rs_val); end
    idle();
  endtask

  task automatic test_round_robin();
    logic [3:0]        exp_rdy;
    logic [3:0]        exp_rsv;
    logic [REQ_SZ-1:0] exp_msg;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rq_val = 4'b1111;
      for (int n = 0; n < 4; n++) rq_msg[n] = REQ_SZ'(43'h100 * 43'(n + 1) + 43'(c));
      memreq_rdy  = 1'b1;
      memresp_val = 1'b1;
      rs_rdy      = 4'b1111;
      #1;
      exp_rdy = 4'b0001 << (c % 4);
      exp_msg = REQ_SZ'(43'h100 * 43'((c % 4) + 1) + 43'(c));
      exp_rsv = (c == 0) ? 4'b0000 : (4'b0001 << ((c + 3) % 4));
      checks++; if (rq_rdy !== exp_rdy) begin failures++; $display("FAIL rr_grant[%0d]: got %b want %b", c, rq_rdy, exp_rdy); end
      checks++; if (memreq_msg !== exp_msg) begin failures++; $display("FAIL rr_msg[%0d]: got %h want %h", c, memreq_msg, exp_msg); end
      checks++; if (rs_val !== exp_rsv) begin failures++; $display("FAIL rr_resp_val[%0d]: got %b want %b", c, rs_val, exp_rsv); end
    end
    idle();
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rq_val     = 4'b0001;
      rq_msg[0]  = REQ_SZ'(43'h40 + 43'(c));
      memreq_rdy = 1'b1;
      rs_rdy     = 4'b1111;
      #1;
      if (c < 4) begin
        checks++; if (memreq_val !== 1'b1) begin failures++; $display("FAIL full_fill_val[%0d]: got %b want 1", c, memreq_val); end
        checks++; if (rq_rdy !== 4'b0001) begin failures++; $display("FAIL full_fill_rdy[%0d]: got %b want 0001", c, rq_rdy); end
      end else begin
        checks++; if (memreq_val !== 1'b0) begin failures++; $display("FAIL full_block_val[%0d]: got %b want 0", c, memreq_val); end
        checks++; if (rq_rdy !== 4'b0000) begin failures++; $display("FAIL full_block_rdy[%0d]: got %b want 0000", c, rq_rdy); end
      end
    end
    @(negedge clk);
    memresp_val = 1'b1;
    #1;
    checks++; if (rs_val !== 4'b0001) begin failures++; $display("FAIL full_pop_val: got %b want 0001", rs_val); end
    checks++; if (memresp_rdy !== 1'b1) begin failures++; $display("FAIL full_pop_rdy: got %b want 1", memresp_rdy); end
    checks++; if (memreq_val !== 1'b0) begin failures++; $display("FAIL full_pushpop_blocked: got %b want 0", memreq_val); end
    checks++; if (rq_rdy !== 4'b0000) begin failures++; $display("FAIL full_pushpop_rdy: got %b want 0000", rq_rdy); end
    @(negedge clk);
    memresp_val = 1'b0;
    #1;
    checks++; if (dut.count_r !== 3'd3) begin failures++; $display("FAIL full_pushpop_count: got %0d want 3", dut.count_r); end
    checks++; if (rq_rdy !== 4'b0001) begin failures++; $display("FAIL full_refill_rdy: got %b want 0001", rq_rdy); end
    @(negedge clk);
    #1;
    checks++; if (dut.count_r !== 3'd4) begin failures++; $display("FAIL full_refill_count: got %0d want 4", dut.count_r); end
    checks++; if (memreq_val !== 1'b0) begin failures++; $display("FAIL full_again_val: got %b want 0", memreq_val); end
    idle();
  endtask

  task automatic test_resp_backpressure();
    do_reset();
    @(negedge clk);
    rq_val     = 4'b0010;
    rq_msg[1]  = REQ_SZ'(43'h77);
    memreq_rdy = 1'b1;
    #1;
    checks++; if (rq_rdy !== 4'b0010) begin failures++; $display("FAIL bp_push_rdy: got %b want 0010", rq_rdy); end
    @(negedge clk);
    rq_val      = 4'b0000;
    memresp_val = 1'b1;
    memresp_msg = RESP_SZ'(35'h9a);
    rs_rdy      = 4'b1101;
    #1;
    checks++; if (rs_val !== 4'b0010) begin failures++; $display("FAIL bp_resp_val: got %b want 0010", rs_val); end
    checks++; if (memresp_rdy !== 1'b0) begin failures++; $display("FAIL bp_memresp_rdy_low: got %b want 0", memresp_rdy); end
    @(negedge clk);
    #1;
    checks++; if (dut.count_r !== 3'd1) begin failures++; $display("FAIL bp_hold_count: got %0d want 1", dut.count_r); end
    rs_rdy = 4'b1111;
    #1;
    checks++; if (memresp_rdy !== 1'b1) begin failures++; $display("FAIL bp_memresp_rdy_high: got %b want 1", memresp_rdy); end
    @(negedge clk);
    #1;
    checks++; if (dut.count_r !== 3'd0) begin failures++; $display("FAIL bp_pop_count: got %0d want 0", dut.count_r); end
    checks++; if (rs_val !== 4'b0000) begin failures++; $display("FAIL bp_after_pop_val: got %b want 0000", rs_val); end
    idle();
  endtask

  task automatic test_push_pop();
    do_reset();
    @(negedge clk);
    rq_val     = 4'b1000;
    memreq_rdy = 1'b1;
    #1;
    checks++; if (rq_rdy !== 4'b1000) begin failures++; $display("FAIL pp_push3_rdy: got %b want 1000", rq_rdy); end
    @(negedge clk);
    rq_val = 4'b0001;
    #1;
    checks++; if (rq_rdy !== 4'b0001) begin failures++; $display("FAIL pp_push0_rdy: got %b want 0001", rq_rdy); end
    @(negedge clk);
    #1;
    checks++; if (dut.count_r !== 3'd2) begin failures++; $display("FAIL pp_count_before: got %0d want 2", dut.count_r); end
    rq_val      = 4'b0010;
    memresp_val = 1'b1;
    rs_rdy      = 4'b1111;
    #1;
    checks++; if (rs_val !== 4'b1000) begin failures++; $display("FAIL pp_head3: got %b want 1000", rs_val); end
    checks++; if (rq_rdy !== 4'b0010) begin failures++; $display("FAIL pp_push1_rdy: got %b want 0010", rq_rdy); end
    @(negedge clk);
    rq_val = 4'b0000;
    #1;
    checks++; if (dut.count_r !== 3'd2) begin failures++; $display("FAIL pp_count_after: got %0d want 2", dut.count_r); end
    checks++; if (rs_val !== 4'b0001) begin failures++; $display("FAIL pp_head0: got %b want 0001", rs_val); end
    @(negedge clk);
    #1;
    checks++; if (rs_val !== 4'b0010) begin failures++; $display("FAIL pp_head1: got %b want 0010", rs_val); end
    @(negedge clk);
    #1;
    checks++; if (rs_val !== 4'b0000) begin failures++; $display("FAIL pp_drained_val: got %b want 0000", rs_val); end
    checks++; if (memresp_rdy !== 1'b0) begin failures++; $display("FAIL pp_drained_rdy: got %b want 0", memresp_rdy); end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rq_val     = 4'b0001;
      memreq_rdy = 1'b1;
    end
    @(negedge clk);
    #1;
    checks++; if (dut.count_r !== 3'd3) begin failures++; $display("FAIL mid_count_before: got %0d want 3", dut.count_r); end
    rq_val = 4'b0000;
    reset  = 1'b1;
    #1;
    checks++; if (memreq_val !== 1'b0) begin failures++; $display("FAIL mid_reset_memreq_val: got %b want 0", memreq_val); end
    @(negedge clk);
    reset       = 1'b0;
    memresp_val = 1'b1;
    rs_rdy      = 4'b1111;
    #1;
    checks++; if (dut.count_r !== 3'd0) begin failures++; $display("FAIL mid_count: got %0d want 0", dut.count_r); end
    checks++; if (dut.ptr_r !== 2'd0) begin failures++; $display("FAIL mid_ptr: got %0d want 0", dut.ptr_r); end
    checks++; if (memresp_rdy !== 1'b0) begin failures++; $display("FAIL mid_memresp_rdy: got %b want 0", memresp_rdy); end
    checks++; if (rs_val !== 4'b0000) begin failures++; $display("FAIL mid_resp_val: got %b want 0000", rs_val); end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_requester();
    test_round_robin();
    test_fifo_full();
    test_resp_backpressure();
    test_push_pop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
